// File: rtl/sopc_cpu_mul_pkg.sv
// sopc_cpu_mul_pkg
// Shared definitions for the multi-cycle multiply unit:
//   mul_mode_e  - operation encoding on the mode port (MUL low half, MULX* high half)
//   mul_state_e - control states IDLE / MUL / FIX
//   sliceCount  - number of partial-product steps for a given operand/slice width
package sopc_cpu_mul_pkg;

  typedef enum logic [1:0] {
    MODE_MUL    = 2'd0,
    MODE_MULXSS = 2'd1,
    MODE_MULXSU = 2'd2,
    MODE_MULXUU = 2'd3
  } mul_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIX  = 2'd2
  } mul_state_e;

  // Number of PART_W-wide slices of the second operand, i.e. MUL-state cycles.
  function automatic int sliceCount(input int dataW, input int partW);
    return dataW / partW;
  endfunction

endpackage

// File: rtl/sopc_cpu_mul_slice.sv
// sopc_cpu_mul_slice
// Purely combinational unsigned DATA_W x PART_W multiplier; one partial product
// per MUL cycle of the parent unit.
// Ports:
//   a_i [DATA_W-1:0]         - full-width unsigned multiplicand
//   b_i [PART_W-1:0]         - one unsigned slice of the multiplier
//   p_o [DATA_W+PART_W-1:0]  - exact unsigned product
module sopc_cpu_mul_slice #(
  parameter int DATA_W = 32,
  parameter int PART_W = 16
) (
  input  logic [DATA_W-1:0]        a_i,
  input  logic [PART_W-1:0]        b_i,
  output logic [DATA_W+PART_W-1:0] p_o
);

  // Zero-extend both factors to the product width so the multiply is exact.
  assign p_o = {{PART_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};

endmodule

// File: rtl/sopc_cpu_mul_unit.sv
// sopc_cpu_mul_unit
// Sequential sign-magnitude multiplier. Operand magnitudes are latched on an
// accepted start, |src1| is multiplied by one PART_W slice of |src2| per MUL
// cycle into a 2*DATA_W accumulator, and FIX applies the sign and selects the
// requested half.
// Ports:
//   clk, reset_n        - clock (rising edge) and asynchronous active-low reset
//   start               - request, accepted only while ready is high
//   mode [1:0]          - 0 MUL low half, 1 MULXSS, 2 MULXSU, 3 MULXUU (high half)
//   src1, src2          - operands, sampled with start
//   ready               - high in IDLE only
//   done                - one-cycle pulse when result is updated
//   result              - selected product half, held until the next done
// Build option: define SOPC_CPU_MUL_EARLY_OUT_EN to leave MUL as soon as all
// remaining |src2| slices are zero. Results are identical in both builds.
module sopc_cpu_mul_unit
  import sopc_cpu_mul_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PART_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int N      = sliceCount(DATA_W, PART_W);
  localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
  localparam int ACC_W  = 2 * DATA_W;
  localparam int PROD_W = DATA_W + PART_W;

  if (((DATA_W % PART_W) != 0) || (PART_W > DATA_W)) begin : gen_bad_params
    $error("sopc_cpu_mul_unit: DATA_W must be a multiple of PART_W and PART_W <= DATA_W");
  end

  mul_state_e        state_q, state_d;
  mul_mode_e         mode_q, mode_d;
  logic [DATA_W-1:0] mag1_q, mag1_d;
  logic [DATA_W-1:0] mag2_q, mag2_d;
  logic              neg_q, neg_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              done_q, done_d;

  logic              src1Neg, src2Neg;
  int unsigned       sliceLsb;
  logic [PART_W-1:0] curSlice;
  logic [PROD_W-1:0] slicePrd;
  logic [ACC_W-1:0]  partial;
  logic [ACC_W-1:0]  signedAcc;
  logic              lastSlice;
  logic              finishMul;

  // An operand is treated as negative only when the mode declares it signed.
  assign src1Neg = ((mode == MODE_MULXSS) || (mode == MODE_MULXSU)) && src1[DATA_W-1];
  assign src2Neg = (mode == MODE_MULXSS) && src2[DATA_W-1];

  assign sliceLsb  = 32'(cnt_q) * PART_W;
  assign curSlice  = mag2_q[sliceLsb +: PART_W];
  assign partial   = ACC_W'(slicePrd) << sliceLsb;
  assign signedAcc = neg_q ? (~acc_q + 1'b1) : acc_q;
  assign lastSlice = (cnt_q == CNT_W'(N - 1));

  sopc_cpu_mul_slice #(
    .DATA_W(DATA_W),
    .PART_W(PART_W)
  ) u_slice (
    .a_i(mag1_q),
    .b_i(curSlice),
    .p_o(slicePrd)
  );

`ifdef SOPC_CPU_MUL_EARLY_OUT_EN
  logic upperZero;

  // Early-out: the multiply is finished once every slice above the one being
  // added this cycle is zero, since those steps would only add zero.
  always_comb begin
    upperZero = 1'b1;
    for (int k = 0; k < N; k++) begin
      if ((k > int'(cnt_q)) && (mag2_q[k*PART_W +: PART_W] != '0)) begin
        upperZero = 1'b0;
      end
    end
  end

  assign finishMul = lastSlice || upperZero;
`else
  assign finishMul = lastSlice;
`endif

  // Next-state and datapath logic. IDLE latches magnitudes and sign on an
  // accepted start, MUL accumulates one shifted partial product per cycle,
  // FIX applies the product sign, picks the half and raises done for a cycle.
  // Inputs are only looked at in IDLE, so changes while busy have no effect.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    mag1_d   = mag1_q;
    mag2_d   = mag2_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = mul_mode_e'(mode);
          mag1_d  = src1Neg ? (~src1 + 1'b1) : src1;
          mag2_d  = src2Neg ? (~src2 + 1'b1) : src2;
          neg_d   = src1Neg ^ src2Neg;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        acc_d = acc_q + partial;
        cnt_d = cnt_q + 1'b1;
        if (finishMul) begin
          state_d = FIX;
        end
      end
      FIX: begin
        result_d = (mode_q == MODE_MUL) ? signedAcc[DATA_W-1:0] : signedAcc[ACC_W-1:DATA_W];
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation without a done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      mode_q   <= MODE_MUL;
      mag1_q   <= '0;
      mag2_q   <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      mag1_q   <= mag1_d;
      mag2_q   <= mag2_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign ready  = (state_q == IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_sopc_cpu_mul_unit.sv
// tb_sopc_cpu_mul_unit
// Self-checking bench for sopc_cpu_mul_unit at default parameters. Expected
// products come from 64-bit integer arithmetic; expected latency from the
// number of significant 16-bit slices of |src2| (early-out build) or the fixed
// three-cycle latency. Honours SOPC_CPU_MUL_EARLY_OUT_EN like the design.
module tb_sopc_cpu_mul_unit;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [1:0]  mode;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        ready;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  sopc_cpu_mul_unit #(
    .DATA_W(32),
    .PART_W(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .mode(mode),
    .src1(src1),
    .src2(src2),
    .ready(ready),
    .done(done),
    .result(result)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference product: exact 64-bit product with each operand sign- or
  // zero-extended as the mode dictates, then the requested half.
  function automatic logic [31:0] refMul(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (m)
      2'd1:    p = 64'(sa * sb);
      2'd2:    p = 64'(sa * ub);
      default: p = 64'(ua * ub);
    endcase
    return (m == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  // Expected cycles from acceptance edge to the edge after which done is seen.
  function automatic int expLat(input logic [1:0] m, input logic [31:0] b);
`ifdef SOPC_CPU_MUL_EARLY_OUT_EN
    logic [31:0] mag;
    mag = ((m == 2'd1) && b[31]) ? (32'd0 - b) : b;
    return (mag[31:16] != 16'd0) ? 3 : 2;
`else
    return (m == 2'd0 || m != 2'd0) ? 3 : 3;
`endif
  endfunction

  // Drive one request at a falling edge, let it be accepted, and wait (bounded)
  // for done. lat is -1 if done never arrived.
  task automatic applyStimulus(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] got, output int lat);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    src1  = a;
    src2  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    mode  = 2'($urandom);
    src1  = $urandom;
    src2  = $urandom;
    lat   = -1;
    got   = 32'hDEAD_BEEF;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = c;
        got = result;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    mode    = 2'd0;
    src1    = '0;
    src2    = '0;
    #1;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", ready); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++;
    if (result !== 32'd0) begin errors++; $display("[TB] FAIL reset_result: got %h expected 0", result); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [1:0]  m [7]  = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
    logic [31:0] a [7]  = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd3, 32'hFFFF_FFFF};
    logic [31:0] b [7]  = '{32'd6, 32'd2, 32'd2, 32'hFFFF_FFFF, 32'h8000_0000, 32'd5, 32'hFFFF_FFFF};
    logic [31:0] want [7] = '{32'h0000_002A, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF,
                              32'h4000_0000, 32'd15, 32'hFFFF_FFFE};
    logic [31:0] got;
    int          lat;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(m[i], a[i], b[i], got, lat);
      checks++;
      if (got !== want[i]) begin
        errors++;
        $display("[TB] FAIL directed%0d_result: got %h expected %h", i, got, want[i]);
      end
      checks++;
      if (lat != expLat(m[i], b[i])) begin
        errors++;
        $display("[TB] FAIL directed%0d_latency: got %0d expected %0d", i, lat, expLat(m[i], b[i]));
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] special [6] = '{32'd0, 32'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_FFFF};
    logic [1:0]  m;
    logic [31:0] a, b, got;
    int          lat;
    for (int i = 0; i < 40; i++) begin
      m = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 3) == 0) b = b & 32'h0000_FFFF;
      applyStimulus(m, a, b, got, lat);
      checks++;
      if (got !== refMul(m, a, b)) begin
        errors++;
        $display("[TB] FAIL random%0d_result mode=%0d a=%h b=%h: got %h expected %h", i, m, a, b, got, refMul(m, a, b));
      end
      checks++;
      if (lat != expLat(m, b)) begin
        errors++;
        $display("[TB] FAIL random%0d_latency: got %0d expected %0d", i, lat, expLat(m, b));
      end
    end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] want;
    int          lat;
    int          extra;
    want = refMul(2'd3, 32'h1234_5678, 32'h9ABC_DEF0);
    @(negedge clk);
    start = 1'b1; mode = 2'd3; src1 = 32'h1234_5678; src2 = 32'h9ABC_DEF0;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; mode = 2'd1; src1 = 32'h0F0F_0F0F; src2 = 32'h8765_4321;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("[TB] FAIL busy_ready: got %b expected 0", ready); end
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = (done === 1'b1) ? 1 : -1;
    for (int c = 2; c <= 12 && lat < 0; c++) begin
      @(posedge clk);
      #1;
      if (done) lat = c;
    end
    checks++;
    if (result !== want) begin errors++; $display("[TB] FAIL busy_result: got %h expected %h", result, want); end
    checks++;
    if (lat != expLat(2'd3, 32'h9ABC_DEF0)) begin
      errors++;
      $display("[TB] FAIL busy_latency: got %0d expected %0d", lat, expLat(2'd3, 32'h9ABC_DEF0));
    end
    extra = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    checks++;
    if (extra != 0) begin errors++; $display("[TB] FAIL busy_extra_done: got %0d expected 0", extra); end
    checks++;
    if (result !== want) begin errors++; $display("[TB] FAIL busy_result_held: got %h expected %h", result, want); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got;
    int          lat;
    applyStimulus(2'd2, 32'hFFFF_FFF0, 32'h0001_0003, got, lat);
    checks++;
    if (got !== refMul(2'd2, 32'hFFFF_FFF0, 32'h0001_0003)) begin
      errors++;
      $display("[TB] FAIL b2b_first_result: got %h expected %h", got, refMul(2'd2, 32'hFFFF_FFF0, 32'h0001_0003));
    end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_with_done: got %b expected 1", ready); end
    applyStimulus(2'd0, 32'hCAFE_0001, 32'h0000_0100, got, lat);
    checks++;
    if (got !== 32'hFE00_0100) begin errors++; $display("[TB] FAIL b2b_second_result: got %h expected %h", got, 32'hFE00_0100); end
    checks++;
    if (lat != expLat(2'd0, 32'h0000_0100)) begin
      errors++;
      $display("[TB] FAIL b2b_second_latency: got %0d expected %0d", lat, expLat(2'd0, 32'h0000_0100));
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] got;
    int          lat;
    int          seen;
    @(negedge clk);
    start = 1'b1; mode = 2'd1; src1 = 32'h8765_4321; src2 = 32'hF000_1234;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_ready: got %b expected 1", ready); end
    checks++;
    if (result !== 32'd0) begin errors++; $display("[TB] FAIL abort_result: got %h expected 0", result); end
    seen = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("[TB] FAIL abort_no_done: got %0d expected 0", seen); end
    applyStimulus(2'd1, 32'hFFFF_FFFD, 32'h0000_0007, got, lat);
    checks++;
    if (got !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL abort_next_result: got %h expected %h", got, 32'hFFFF_FFFF); end
    checks++;
    if (lat != expLat(2'd1, 32'h0000_0007)) begin
      errors++;
      $display("[TB] FAIL abort_next_latency: got %0d expected %0d", lat, expLat(2'd1, 32'h0000_0007));
    end
  endtask

  // Scenario sequence followed by the single summary line.
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sopc_cpu_mul_unit.md
SOPC_CPU_MUL_UNIT -- requirements
Module: sopc_cpu_mul_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32: operand and result width.
REQ-002 SHALL have parameter PART_W, default 16: slice width of one partial-product step; elaboration SHALL fail unless DATA_W % PART_W == 0 and PART_W <= DATA_W.
REQ-003 SHALL have port clk  input  1: single clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1: request; accepted only on a rising edge where ready=1.
REQ-006 SHALL have port mode  input  2: 0=MUL (low half), 1=MULXSS, 2=MULXSU (src1 signed, src2 unsigned), 3=MULXUU (modes 1-3 return the high half).
REQ-007 SHALL have ports src1 and src2  input  DATA_W: operands, sampled with start.
REQ-008 SHALL have port ready  output  1: high in IDLE only.
REQ-009 SHALL have port done  output  1: one-cycle pulse, result valid.
REQ-010 SHALL have port result  output  DATA_W: selected product half, held until the next done.

Function
REQ-011 SHALL use states IDLE, MUL, FIX; IDLE->MUL on accepted start; MUL->FIX after the last slice; FIX->IDLE unconditionally.
REQ-012 SHALL on acceptance latch |src1| and |src2| (magnitude when that operand is signed per mode and negative, else raw), the product sign = XOR of operand signs, the mode, and clear a 2*DATA_W accumulator and slice counter.
REQ-013 SHALL in MUL, each cycle, add (|src1| * slice i of |src2|) << (i*PART_W) into the accumulator, i = 0..N-1, N = DATA_W/PART_W.
REQ-014 SHALL in FIX negate the accumulator if sign=1, register result (bits [DATA_W-1:0] for mode 0, else [2*DATA_W-1:DATA_W]), and assert done.
REQ-015 SHALL give latency N+1: done high in the cycle after the (N+1)th rising edge following acceptance (3 cycles at defaults).
REQ-016 SHALL treat the magnitude of the most-negative value (-2^(DATA_W-1)) as unsigned 2^(DATA_W-1), giving an exact product.
REQ-017 SHALL ignore start while ready=0; mode/src changes in MUL/FIX SHALL have no effect.
REQ-018 SHALL allow back-to-back operation: start accepted in the cycle done is high (ready is already 1 in IDLE after FIX).

Reset
REQ-019 SHALL on reset_n low, immediately: state=IDLE, ready=1, done=0, result=0, accumulator and counter cleared.
REQ-020 SHALL abort any operation in progress on reset, with no done pulse for it.

Configuration
REQ-021 SHALL, when SOPC_CPU_MUL_EARLY_OUT_EN is defined, go MUL->FIX as soon as all |src2| slices above the current one are zero (minimum latency 2).
REQ-022 SHALL, without SOPC_CPU_MUL_EARLY_OUT_EN, always execute N MUL cycles (fixed latency N+1); results SHALL be identical in both builds.

Structure
REQ-023 SHALL take the mode encoding, state enum and a slice-count constant function from shared package sopc_cpu_mul_pkg.
REQ-024 SHALL instantiate one sub-module sopc_cpu_mul_slice: combinational unsigned DATA_W x PART_W multiplier, (DATA_W+PART_W)-bit output.

Verification
REQ-025 SHALL check mode 0, src1=7, src2=6 -> result=0x0000002A, done exactly 3 cycles after acceptance (early-out off).
REQ-026 SHALL check src1=0xFFFFFFFF, src2=2: mode 1 -> 0xFFFFFFFF; mode 3 -> 0x00000001; mode 2 with src2=0xFFFFFFFF -> 0xFFFFFFFF.
REQ-027 SHALL check mode 1, src1=src2=0x80000000 -> result=0x40000000.
REQ-028 SHALL check early-out build, mode 0, src2=5, src1=3 -> result=15 with done after 2 cycles; same stimulus without the macro -> 3 cycles.
REQ-029 SHALL check start pulsed while busy with different operands -> ignored, first result unchanged, no extra done.
REQ-030 SHALL check reset_n asserted during MUL -> ready=1, result=0 immediately, no done; a new operation after release is correct.
